// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor: default geometry,
// counter saturation arithmetic and the table index hash.
package bp_pkg;

  // Default geometry of the predictor table
  localparam int DEF_IDX_W    = 5;
  localparam int DEF_CTR_BITS = 2;
  localparam int ENTRIES      = 1 << DEF_IDX_W;
  localparam int CTR_MAX      = (1 << DEF_CTR_BITS) - 1;

  // Widest counter and index the helpers below are written for
  localparam int MAX_CTR_W = 4;
  localparam int MAX_IDX_W = 16;

  // Largest value a counter of ctr_bits bits can hold
  function automatic int ctr_max(input int ctr_bits);
    return (1 << ctr_bits) - 1;
  endfunction

  // Saturating up/down step; never wraps at either end
  function automatic logic [MAX_CTR_W-1:0] sat_next(
    input logic [MAX_CTR_W-1:0] ctr,
    input logic                 taken,
    input int                   ctr_bits
  );
    logic [MAX_CTR_W-1:0] top;
    logic [MAX_CTR_W-1:0] res;
    top = MAX_CTR_W'(ctr_max(ctr_bits));
    if (taken) begin
      if (ctr >= top) begin
        res = top;
      end else begin
        res = ctr + 4'd1;
      end
    end else begin
      if (ctr == 4'd0) begin
        res = 4'd0;
      end else begin
        res = ctr - 4'd1;
      end
    end
    return res;
  endfunction

  // gshare hash: PC index bits folded with zero-extended global history
  function automatic logic [MAX_IDX_W-1:0] idx_hash(
    input logic [MAX_IDX_W-1:0] idx,
    input logic [MAX_IDX_W-1:0] hist
  );
    return idx ^ hist;
  endfunction

endpackage

// File: rtl/bp_sat_counter_next.sv
// Combinational next-state of one saturating counter. The predictor uses a
// single instance on its write port; the read bypass reuses the same result.
module bp_sat_counter_next
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                taken_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  logic [MAX_CTR_W-1:0] ctr_ext_s;
  logic [MAX_CTR_W-1:0] ctr_sat_s;

  // Widen to the helper width, step with saturation, narrow back
  always_comb begin
    ctr_ext_s = MAX_CTR_W'(ctr_i);
    ctr_sat_s = sat_next(ctr_ext_s, taken_i, CTR_BITS);
    ctr_o     = CTR_BITS'(ctr_sat_s);
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Flop-based gshare / bimodal branch predictor with speculative global
// history, mispredict recovery and a same-cycle update-to-predict bypass.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int IDX_W    = 5,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 5,
  parameter int CTR_INIT = 1,
  localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_out_valid,
  output logic             pred_taken,
  output logic [GW-1:0]    pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [GW-1:0]    upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispredict
);

  localparam int NUM_ENT = 1 << IDX_W;

  logic [CTR_BITS-1:0] ctr_q [NUM_ENT];
  logic [GW-1:0]       ghr_q;
  logic [GW-1:0]       ghr_d;
  logic                pred_out_valid_q;
  logic                pred_taken_q;
  logic                pred_taken_d;
  logic [GW-1:0]       pred_ghr_q;
  logic [GW-1:0]       pred_ghr_d;

  logic [IDX_W-1:0]    rd_hist_s;
  logic [IDX_W-1:0]    wr_hist_s;
  logic [IDX_W-1:0]    rd_idx_s;
  logic [IDX_W-1:0]    wr_idx_s;
  logic [CTR_BITS-1:0] ctr_wr_cur_s;
  logic [CTR_BITS-1:0] ctr_wr_next_s;
  logic                bypass_s;
  logic                pred_bit_s;

  // History contribution to the hash; bimodal mode ties GHR logic off
  if (GHR_BITS > 0) begin : g_hist
    // Hash inputs come from the live GHR (read) and the returned snapshot (write)
    always_comb begin
      rd_hist_s = IDX_W'(ghr_q);
      wr_hist_s = IDX_W'(upd_ghr);
    end

    // Recovery beats the speculative shift; otherwise shift in the prediction
    always_comb begin
      if (upd_valid && upd_mispredict) begin
        ghr_d = GW'({upd_ghr, upd_taken});
      end else if (pred_valid) begin
        ghr_d = GW'({ghr_q, pred_bit_s});
      end else begin
        ghr_d = ghr_q;
      end
    end
  end else begin : g_no_hist
    // Pure bimodal: raw indices, history held at zero
    always_comb begin
      rd_hist_s = '0;
      wr_hist_s = '0;
      ghr_d     = '0;
    end
  end

  // Effective table indices for the predict and update ports
  always_comb begin
    rd_idx_s = IDX_W'(idx_hash(MAX_IDX_W'(pred_idx), MAX_IDX_W'(rd_hist_s)));
    wr_idx_s = IDX_W'(idx_hash(MAX_IDX_W'(upd_idx), MAX_IDX_W'(wr_hist_s)));
  end

  // Current value of the counter being updated
  always_comb begin
    ctr_wr_cur_s = ctr_q[wr_idx_s];
  end

  bp_sat_counter_next #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_next (
    .ctr_i   (ctr_wr_cur_s),
    .taken_i (upd_taken),
    .ctr_o   (ctr_wr_next_s)
  );

  // Predicted direction, forwarding the post-update counter on an index hit
  always_comb begin
    bypass_s = upd_valid && (wr_idx_s == rd_idx_s);
    if (bypass_s) begin
      pred_bit_s = ctr_wr_next_s[CTR_BITS-1];
    end else begin
      pred_bit_s = ctr_q[rd_idx_s][CTR_BITS-1];
    end
  end

  // Output register next-state: capture on request, otherwise hold
  always_comb begin
    if (pred_valid) begin
      pred_taken_d = pred_bit_s;
      pred_ghr_d   = ghr_q;
    end else begin
      pred_taken_d = pred_taken_q;
      pred_ghr_d   = pred_ghr_q;
    end
  end

  // Counter table: reset to CTR_INIT, one saturating write per cycle
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        ctr_q[i] <= CTR_BITS'(CTR_INIT);
      end
    end else if (upd_valid) begin
      ctr_q[wr_idx_s] <= ctr_wr_next_s;
    end else begin
      ctr_q[wr_idx_s] <= ctr_q[wr_idx_s];
    end
  end

  // Global history and registered prediction outputs
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ghr_q            <= '0;
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_ghr_q       <= '0;
    end else begin
      ghr_q            <= ghr_d;
      pred_out_valid_q <= pred_valid;
      pred_taken_q     <= pred_taken_d;
      pred_ghr_q       <= pred_ghr_d;
    end
  end

  assign pred_out_valid = pred_out_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_ghr       = pred_ghr_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: a gshare instance (GHR_BITS=5) and a
// bimodal instance (GHR_BITS=0) share stimulus and are both checked against
// an integer reference model; a directed table also carries hand-derived
// expectations for the gshare instance.
module tb_branch_predictor_gshare;

  logic       clk;
  logic       arst;
  logic       pv;
  logic [4:0] pidx;
  logic       uv;
  logic [4:0] uidx;
  logic [4:0] ughr;
  logic       ut;
  logic       um;

  logic       g_ov, g_t;
  logic [4:0] g_g;
  logic       b_ov, b_t;
  logic [0:0] b_g;

  int checks;
  int failures;

  // Reference model state (index 0 = gshare, 1 = bimodal)
  int mctr [2][32];
  int mghr [2];
  int gbits [2];
  int e_ov [2];
  int e_t  [2];
  int e_g  [2];

  typedef struct {
    logic       pv;
    logic [4:0] pidx;
    logic       uv;
    logic [4:0] uidx;
    logic [4:0] ughr;
    logic       ut;
    logic       um;
    logic       eov;
    logic       et;
    logic [4:0] eg;
  } vec_t;

  vec_t vecs [21];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_gshare u_gs (
    .clk            (clk),
    .arst           (arst),
    .pred_valid     (pv),
    .pred_idx       (pidx),
    .pred_out_valid (g_ov),
    .pred_taken     (g_t),
    .pred_ghr       (g_g),
    .upd_valid      (uv),
    .upd_idx        (uidx),
    .upd_ghr        (ughr),
    .upd_taken      (ut),
    .upd_mispredict (um)
  );

  branch_predictor_gshare #(.GHR_BITS(0)) u_bm (
    .clk            (clk),
    .arst           (arst),
    .pred_valid     (pv),
    .pred_idx       (pidx),
    .pred_out_valid (b_ov),
    .pred_taken     (b_t),
    .pred_ghr       (b_g),
    .upd_valid      (uv),
    .upd_idx        (uidx),
    .upd_ghr        (ughr[0:0]),
    .upd_taken      (ut),
    .upd_mispredict (um)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 32; i++) mctr[m][i] = 1;
      mghr[m] = 0;
      e_ov[m] = 0;
      e_t[m]  = 0;
      e_g[m]  = 0;
    end
  endtask

  // Apply the rules for the inputs currently driven; state advances at the edge
  task automatic model_predict();
    int mask, rd, wr, cur, newc, used, bitv;
    for (int m = 0; m < 2; m++) begin
      mask = (1 << gbits[m]) - 1;
      rd   = (int'(pidx) ^ mghr[m]) & 31;
      wr   = (int'(uidx) ^ (int'(ughr) & mask)) & 31;
      cur  = mctr[m][wr];
      if (ut) newc = (cur + 1 > 3) ? 3 : cur + 1;
      else    newc = (cur - 1 < 0) ? 0 : cur - 1;
      used = (uv && (wr == rd)) ? newc : mctr[m][rd];
      bitv = (used >= 2) ? 1 : 0;
      e_ov[m] = int'(pv);
      if (pv) begin
        e_t[m] = bitv;
        e_g[m] = mghr[m];
      end
      if (uv) mctr[m][wr] = newc;
      if (uv && um) mghr[m] = ((int'(ughr) << 1) | int'(ut)) & mask;
      else if (pv)  mghr[m] = ((mghr[m] << 1) | bitv) & mask;
    end
  endtask

  task automatic compare_model();
    chk("gs_out_valid", 32'(g_ov), e_ov[0]);
    chk("gs_taken",     32'(g_t),  e_t[0]);
    chk("gs_ghr",       32'(g_g),  e_g[0]);
    chk("bm_out_valid", 32'(b_ov), e_ov[1]);
    chk("bm_taken",     32'(b_t),  e_t[1]);
    chk("bm_ghr",       32'(b_g),  e_g[1]);
  endtask

  task automatic step();
    model_predict();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    pv = 1'b0; pidx = 5'd0; uv = 1'b0; uidx = 5'd0;
    ughr = 5'd0; ut = 1'b0; um = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    gbits[0] = 5;
    gbits[1] = 0;

    // Directed sequence from reset: {pv,pidx,uv,uidx,ughr,ut,um, exp ov,taken,ghr}
    vecs[0]  = '{1'b0, 5'd0,  1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{1'b0, 5'd0,  1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[2]  = '{1'b1, 5'd7,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd0};
    vecs[3]  = '{1'b0, 5'd0,  1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
    vecs[4]  = '{1'b0, 5'd0,  1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
    vecs[5]  = '{1'b0, 5'd0,  1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
    vecs[6]  = '{1'b0, 5'd0,  1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
    vecs[7]  = '{1'b0, 5'd0,  1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
    vecs[8]  = '{1'b1, 5'd6,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd1};
    vecs[9]  = '{1'b0, 5'd0,  1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd1};
    vecs[10] = '{1'b1, 5'd4,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd3};
    vecs[11] = '{1'b0, 5'd0,  1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[12] = '{1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd7};
    vecs[13] = '{1'b1, 5'd10, 1'b1, 5'd4,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd14};
    vecs[14] = '{1'b1, 5'd0,  1'b1, 5'd0,  5'd22, 1'b1, 1'b1, 1'b1, 1'b0, 5'd29};
    vecs[15] = '{1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd13};
    vecs[16] = '{1'b0, 5'd0,  1'b1, 5'd2,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 5'd13};
    vecs[17] = '{1'b0, 5'd0,  1'b1, 5'd2,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 5'd13};
    vecs[18] = '{1'b0, 5'd0,  1'b1, 5'd30, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 5'd13};
    vecs[19] = '{1'b1, 5'd2,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd1};
    vecs[20] = '{1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd1};

    // Power-on reset
    arst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    compare_model();

    // Reset then idle: every entry weakly not-taken, one-cycle latency
    for (int i = 0; i < 32; i++) begin
      pv = 1'b1;
      pidx = 5'(i);
      step();
      chk("sweep_gs_taken", 32'(g_t), 32'd0);
      chk("sweep_bm_valid", 32'(b_ov), 32'd1);
    end
    idle_inputs();
    step();

    // Fresh state for the directed table
    arst = 1'b1;
    #1;
    arst = 1'b0;
    model_reset();
    for (int i = 0; i < 21; i++) begin
      pv = vecs[i].pv; pidx = vecs[i].pidx; uv = vecs[i].uv;
      uidx = vecs[i].uidx; ughr = vecs[i].ughr; ut = vecs[i].ut; um = vecs[i].um;
      step();
      chk("vec_out_valid", 32'(g_ov), 32'(vecs[i].eov));
      chk("vec_taken",     32'(g_t),  32'(vecs[i].et));
      chk("vec_ghr",       32'(g_g),  32'(vecs[i].eg));
    end

    // Mid-stream reset with a prediction in flight
    idle_inputs();
    pv = 1'b1;
    pidx = 5'd2;
    step();
    pv = 1'b0;
    #2;
    arst = 1'b1;
    #1;
    chk("arst_gs_valid", 32'(g_ov), 32'd0);
    chk("arst_gs_taken", 32'(g_t),  32'd0);
    chk("arst_gs_ghr",   32'(g_g),  32'd0);
    chk("arst_bm_taken", 32'(b_t),  32'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
    // Entry 3 was trained to strongly taken before the reset
    pv = 1'b1;
    pidx = 5'd3;
    step();
    chk("post_rst_taken", 32'(g_t), 32'd0);
    chk("post_rst_ghr",   32'(g_g), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      pv   = 1'($urandom_range(0, 1));
      pidx = 5'($urandom_range(0, 31));
      uv   = 1'($urandom_range(0, 1));
      uidx = 5'($urandom_range(0, 31));
      ughr = 5'($urandom_range(0, 31));
      ut   = 1'($urandom_range(0, 1));
      um   = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 7) == 0) uidx = pidx;
      step();
    end

    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised successor to the 2-bit branch history table. Holds 2^IDX_W saturating counters of CTR_BITS each, indexed either bimodally (PC bits) or gshare-style (PC bits XOR global history). Sits in the fetch/decode stage: the predict port is queried with the current PC index, and the update port is driven from the branch-resolve stage. Adds speculative global history, mispredict recovery and a same-cycle write-to-read bypass.

Parameters:
IDX_W, 5, table index width; 2^IDX_W entries (32 by default).
CTR_BITS, 2, counter width; legal range 1..4.
GHR_BITS, 5, global history length; 0 selects pure bimodal mode; legal range 0..IDX_W.
CTR_INIT, 1, counter reset value (weakly not-taken for 2 bits); must be below 2^CTR_BITS.

Ports:
clk  in  1  clock; all state changes on the rising edge
arst  in  1  asynchronous reset, active-high
pred_valid  in  1  prediction request this cycle
pred_idx  in  IDX_W  PC index bits of the branch being predicted
pred_out_valid  out  1  registered; high one cycle after pred_valid
pred_taken  out  1  registered prediction, equal to the MSB of the indexed counter
pred_ghr  out  max(GHR_BITS,1)  registered GHR snapshot used for this prediction; the pipeline must carry it to resolve
upd_valid  in  1  resolved branch update
upd_idx  in  IDX_W  PC index of the resolved branch
upd_ghr  in  max(GHR_BITS,1)  GHR snapshot returned from pred_ghr
upd_taken  in  1  actual branch outcome
upd_mispredict  in  1  outcome differed from the prediction; qualified by upd_valid

Behaviour:
- Reset (async assert): all counters = CTR_INIT, GHR = 0, pred_out_valid = 0, pred_taken = 0, pred_ghr = 0. Release is synchronous to clk.
- Index function: in gshare mode, rd_idx = pred_idx XOR zero-extended GHR and wr_idx = upd_idx XOR zero-extended upd_ghr. When GHR_BITS = 0, the raw index is used and the GHR, upd_ghr and pred_ghr logic is tied off with pred_ghr = 0.
- Latency: exactly 1 cycle from pred_valid to pred_out_valid, pred_taken and pred_ghr. Without pred_valid, pred_out_valid = 0 next cycle and pred_taken/pred_ghr hold their previous values.
- Counter update (upd_valid = 1):
  - Taken: ctr = min(ctr + 1, 2^CTR_BITS - 1).
  - Not taken: ctr = max(ctr - 1, 0).
  - Saturation must never wrap; for example 3 with taken stays 3, and 0 with not-taken stays 0.
- Bypass: if pred_valid and upd_valid target the same effective index in the same cycle, the prediction uses the post-update counter value.
- GHR speculative update: on pred_valid, GHR_next = {GHR[GHR_BITS-2:0], predicted bit}, where the predicted bit is the MSB of the counter value actually used, including any bypass.
- GHR recovery: upd_valid with upd_mispredict sets GHR_next = {upd_ghr[GHR_BITS-2:0], upd_taken}.
  - Recovery has priority over the speculative shift in the same cycle.
  - The prediction issued in that cycle still uses the pre-recovery GHR for indexing and for the pred_ghr snapshot.
- upd_valid without upd_mispredict updates the counter only; the GHR is not touched.
- Mid-operation reset: all counters and the GHR return to reset values immediately; any in-flight pred_out_valid drops to 0.
- Storage is flop-based, not an SRAM macro: reads are combinational into the output register, so there are no read-port hazards.

Decomposition:
- Package bp_pkg holds:
  - function sat_next(ctr, taken, CTR_BITS);
  - the index-hash function;
  - localparams ENTRIES = 1 << IDX_W and CTR_MAX.
- Natural sub-module: bp_sat_counter_next, the combinational saturating next-state for one counter. One instance serves the write port; the bypass reuses its output.

Test Plan:
1. Reset then idle -> every entry reads weakly not-taken. With GHR_BITS = 0, pred_idx = 0..31 gives pred_taken = 0 and pred_out_valid = 1 one cycle after each request.
2. Bimodal: upd idx 7 taken ×2 -> predict idx 7 gives 1. Then taken ×5 more -> counter holds 3 (no wrap). Then not-taken ×1 -> still 1, not-taken ×1 more -> 0.
3. Same-cycle bypass: counter[4] = 1; upd_valid idx 4 taken together with pred_valid idx 4 -> pred_taken = 1 next cycle.
4. Gshare history, GHR_BITS = 5:
   - Train idx 3 with GHR = 5'b00001 taken ×2.
   - Predict idx 2 three times (all not-taken, GHR shifts to 0).
   - Then force the GHR to 00001 via recovery.
   - Predict idx 2 -> effective index 3 -> pred_taken = 1, pred_ghr = 00001.
5. Mispredict recovery priority: pred_valid together with upd_mispredict, upd_ghr = 5'b10110, upd_taken = 1 -> GHR = 5'b01101 next cycle (speculative shift discarded). That cycle's pred_ghr shows the old GHR.
6. Reset mid-stream: assert arst asynchronously between edges after training -> outputs go to 0 immediately. After release, a previously trained index predicts 0 and GHR = 0.
